// File: rtl/trace_capture_pkg.sv
// trace_capture_pkg: shared state encoding and window-size helpers
// for the trace capture block.
package trace_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_TRIG,
        POST,
        READOUT
    } state_e;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Post window is clipped so pre + 1 + post never exceeds the RAM depth.
    function automatic int unsigned clamp_post(input int unsigned pre,
                                               input int unsigned post,
                                               input int unsigned aw);
        int unsigned lim;
        lim = depth(aw) - 32'd1 - pre;
        return (post < lim) ? post : lim;
    endfunction

    function automatic int unsigned win_len(input int unsigned pre,
                                            input int unsigned post);
        return pre + 32'd1 + post;
    endfunction

endpackage

// File: rtl/trace_capture_if.sv
// trace_capture_if: control, sample-in and readout stream bundle
// between the capture block and its host/compare-stage neighbours.
interface trace_capture_if #(
    parameter int DataBits = 32,
    parameter int SyncBits = 1,
    parameter int AddrBits = 10
);
    logic                arm;
    logic                abort;
    logic [AddrBits-1:0] pre_count;
    logic [AddrBits-1:0] post_count;
    logic                din_valid;
    logic [DataBits-1:0] din_data;
    logic [SyncBits-1:0] din_sync;
    logic                din_trig;
    logic                dout_valid;
    logic                dout_ready;
    logic [DataBits-1:0] dout_data;
    logic [SyncBits-1:0] dout_sync;
    logic                dout_trig;
    logic                dout_last;
    logic                armed;
    logic                triggered;

    modport master (
        output arm, abort, pre_count, post_count,
        output din_valid, din_data, din_sync, din_trig,
        output dout_ready,
        input  dout_valid, dout_data, dout_sync, dout_trig, dout_last,
        input  armed, triggered
    );

    modport slave (
        input  arm, abort, pre_count, post_count,
        input  din_valid, din_data, din_sync, din_trig,
        input  dout_ready,
        output dout_valid, dout_data, dout_sync, dout_trig, dout_last,
        output armed, triggered
    );
endinterface

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port trace storage, one write port and
// one registered read port, no reset on the array or read data.
module trace_ram #(
    parameter int Width    = 33,
    parameter int AddrBits = 10
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AddrBits-1:0] i_waddr,
    input  logic [Width-1:0]    i_wdata,
    input  logic [AddrBits-1:0] i_raddr,
    output logic [Width-1:0]    o_rdata
);
    logic [Width-1:0] r_mem [2**AddrBits];

    // Write when enabled; read data is available one cycle after the address.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/trace_capture.sv
// trace_capture: circular trace buffer with a pre-trigger window and
// ready/valid replay of the captured window through a 2-entry skid buffer.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DataBits = 32,
    parameter int SyncBits = 1,
    parameter int AddrBits = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    trace_capture_if.slave bus
);
    localparam int W  = DataBits + SyncBits;
    localparam int CW = AddrBits + 1;
    localparam int EW = W + 2;

    state_e              r_state, w_next;
    logic [AddrBits-1:0] r_wptr, r_raddr, r_pre, r_post, r_cnt;
    logic [AddrBits-1:0] w_post_clamp;
    logic [CW-1:0]       r_ridx, w_n;
    logic                r_pend, r_pend_trig, r_pend_last;
    logic [EW-1:0]       r_fifo [2];
    logic                r_head;
    logic [1:0]          r_fcnt, w_occ;
    logic [W-1:0]        w_rdata;
    logic [EW-1:0]       w_out;
    logic                w_take, w_we, w_cap, w_pop, w_issue;
    logic                w_valid, w_arm_ok;

    assign w_valid  = (r_fcnt != 2'd0);
    assign w_out    = r_fifo[r_head];
    assign w_pop    = w_valid && bus.dout_ready;
    assign w_take   = bus.din_valid && !bus.abort;
    assign w_we     = w_take && (r_state inside {FILL, WAIT_TRIG, POST});
    assign w_cap    = w_take && bus.din_trig && (r_state == WAIT_TRIG);
    assign w_arm_ok = bus.arm && !bus.abort && (r_state == IDLE);
    assign w_post_clamp = AddrBits'(clamp_post(32'(bus.pre_count),
                                               32'(bus.post_count),
                                               32'(AddrBits)));
    assign w_n      = CW'(win_len(32'(r_pre), 32'(r_post)));
    // Occupancy counts skid entries plus the read still in flight.
    assign w_occ    = r_fcnt + {1'b0, r_pend};
    assign w_issue  = (r_state == READOUT) && (r_ridx != w_n) &&
                      (w_occ < 2'd2 || (w_occ == 2'd2 && w_pop));

    assign bus.dout_valid = w_valid;
    assign bus.dout_data  = w_out[DataBits-1:0];
    assign bus.dout_sync  = w_out[W-1:DataBits];
    assign bus.dout_trig  = w_valid && w_out[W];
    assign bus.dout_last  = w_valid && w_out[W+1];
    assign bus.armed      = (r_state == FILL) || (r_state == WAIT_TRIG);
    assign bus.triggered  = (r_state == POST) || (r_state == READOUT);

    trace_ram #(
        .Width    (W),
        .AddrBits (AddrBits)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata ({bus.din_sync, bus.din_data}),
        .i_raddr (r_raddr),
        .o_rdata (w_rdata)
    );

    // Capture state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; abort overrides every other event.
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:
                    if (bus.arm)
                        w_next = (bus.pre_count == '0) ? WAIT_TRIG : FILL;
                FILL:
                    if (w_we && r_cnt == r_pre - 1'b1) w_next = WAIT_TRIG;
                WAIT_TRIG:
                    if (w_cap) w_next = (r_post == '0) ? READOUT : POST;
                POST:
                    if (w_we && r_cnt == r_post - 1'b1) w_next = READOUT;
                READOUT:
                    if (w_pop && w_out[W+1]) w_next = IDLE;
                default:
                    w_next = IDLE;
            endcase
        end
    end

    // Write pointer, latched window, sample counter and read sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_raddr     <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_cnt       <= '0;
            r_ridx      <= '0;
            r_pend      <= 1'b0;
            r_pend_trig <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (w_we) r_wptr <= r_wptr + 1'b1;
            if (w_arm_ok) begin
                r_pre  <= bus.pre_count;
                r_post <= w_post_clamp;
                r_cnt  <= '0;
            end else if (w_cap) begin
                r_cnt <= '0;
            end else if (w_we) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_cap) begin
                r_raddr <= r_wptr - r_pre;
                r_ridx  <= '0;
            end else if (w_issue) begin
                r_raddr <= r_raddr + 1'b1;
                r_ridx  <= r_ridx + 1'b1;
            end
            r_pend      <= w_issue && !bus.abort;
            r_pend_trig <= (r_ridx == {1'b0, r_pre});
            r_pend_last <= (r_ridx == w_n - 1'b1);
        end
    end

    // Skid buffer occupancy and head pointer; abort flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= 1'b0;
            r_fcnt <= 2'd0;
        end else if (bus.abort) begin
            r_head <= 1'b0;
            r_fcnt <= 2'd0;
        end else begin
            if (w_pop) r_head <= ~r_head;
            r_fcnt <= r_fcnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

    // Skid buffer storage; each RAM read lands behind the current entries.
    always_ff @(posedge clk) begin
        if (r_pend && !bus.abort)
            r_fifo[r_head ^ r_fcnt[0]] <= {r_pend_last, r_pend_trig, w_rdata};
    end
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: randomized capture/readout scenarios checked against
// a sample-list model of the trigger window.
module tb_trace_capture;
    localparam int DW = 32;
    localparam int SW = 1;
    localparam int AW = 4;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    trace_capture_if #(.DataBits(DW), .SyncBits(SW), .AddrBits(AW)) ifc ();

    trace_capture #(
        .DataBits (DW),
        .SyncBits (SW),
        .AddrBits (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    task automatic idle_inputs();
        ifc.arm        = 1'b0;
        ifc.abort      = 1'b0;
        ifc.pre_count  = '0;
        ifc.post_count = '0;
        ifc.din_valid  = 1'b0;
        ifc.din_data   = '0;
        ifc.din_sync   = '0;
        ifc.din_trig   = 1'b0;
        ifc.dout_ready = 1'b0;
    endtask

    task automatic pulse_arm(input int pre, input int post);
        ifc.pre_count  = AW'(pre);
        ifc.post_count = AW'(post);
        ifc.arm        = 1'b1;
        @(negedge clk);
        ifc.arm = 1'b0;
    endtask

    task automatic feed(input int n, input int trig_idx);
        for (int i = 0; i < n; i++) begin
            ifc.din_valid = 1'b1;
            ifc.din_trig  = (i == trig_idx);
            ifc.din_data  = $urandom;
            ifc.din_sync  = SW'($urandom);
            @(negedge clk);
        end
        ifc.din_valid = 1'b0;
        ifc.din_trig  = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (ifc.dout_valid !== 1'b0 || ifc.armed !== 1'b0 ||
            ifc.triggered !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: valid=%b armed=%b trig'd=%b want 0 0 0",
                     nm, ifc.dout_valid, ifc.armed, ifc.triggered);
        end
    endtask

    task automatic run_capture(input string nm, input int pre, input int post,
                               input logic [63:0] tmap, input int gap_pct,
                               input int rdy_pct, input bit seq_data);
        logic [DW-1:0] md[$];
        logic [SW-1:0] ms[$];
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        logic          pt, pl, pv, prdy, v, t;
        int            ep, n, idx, k, j, lat, bub;
        bit            done, seen;
        ep   = (post < D - 1 - pre) ? post : D - 1 - pre;
        n    = pre + 1 + ep;
        idx  = 0; k = -1; j = 0; lat = 0; bub = 0;
        done = 0; seen = 0;
        pv = 0; prdy = 0; pd = '0; ps = '0; pt = 0; pl = 0;
        pulse_arm(pre, post);
        checks++;
        if (ifc.armed !== 1'b1) begin
            errors++;
            $display("FAIL %s armed: got %b want 1", nm, ifc.armed);
        end
        for (int cyc = 0; cyc < 600 && j < n; cyc++) begin
            if (done && ifc.dout_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (lat > 2 || ifc.triggered !== 1'b1 || ifc.armed !== 1'b0) begin
                        errors++;
                        $display("FAIL %s first_out: lat=%0d trig'd=%b armed=%b want <=2 1 0",
                                 nm, lat, ifc.triggered, ifc.armed);
                    end
                end
                if (pv && !prdy) begin
                    checks++;
                    if ({ifc.dout_data, ifc.dout_sync, ifc.dout_trig, ifc.dout_last}
                        !== {pd, ps, pt, pl}) begin
                        errors++;
                        $display("FAIL %s stall_stable: got %h/%b/%b/%b want %h/%b/%b/%b",
                                 nm, ifc.dout_data, ifc.dout_sync, ifc.dout_trig,
                                 ifc.dout_last, pd, ps, pt, pl);
                    end
                end
            end else if (done && !seen) begin
                lat++;
            end else if (done) begin
                bub++;
            end else begin
                checks++;
                if (ifc.dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_valid: got %b want 0", nm, ifc.dout_valid);
                end
            end
            prdy = ($urandom_range(99) < rdy_pct);
            ifc.dout_ready = prdy;
            if (!done) begin
                v = ($urandom_range(99) >= gap_pct);
                t = tmap[idx % 64];
                ifc.din_valid = v;
                ifc.din_trig  = t;
                ifc.din_data  = seq_data ? DW'(idx) : DW'($urandom);
                ifc.din_sync  = SW'($urandom);
                if (v) begin
                    md.push_back(ifc.din_data);
                    ms.push_back(ifc.din_sync);
                    if (k < 0 && t && md.size() > pre) k = md.size() - 1;
                    idx++;
                    if (k >= 0 && md.size() == k + 1 + ep) done = 1;
                end
            end else begin
                ifc.din_valid = 1'($urandom_range(1));
                ifc.din_trig  = 1'b1;
                ifc.din_data  = $urandom;
                ifc.din_sync  = SW'($urandom);
            end
            if (done && ifc.dout_valid === 1'b1 && prdy) begin
                checks++;
                if (ifc.dout_data !== md[k-pre+j] || ifc.dout_sync !== ms[k-pre+j] ||
                    ifc.dout_trig !== (j == pre) || ifc.dout_last !== (j == n - 1)) begin
                    errors++;
                    $display("FAIL %s sample[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b",
                             nm, j, ifc.dout_data, ifc.dout_sync, ifc.dout_trig,
                             ifc.dout_last, md[k-pre+j], ms[k-pre+j], (j == pre),
                             (j == n - 1));
                end
                if (j == n - 1) ifc.arm = 1'b1;
                j++;
            end
            pv = ifc.dout_valid;
            pd = ifc.dout_data;
            ps = ifc.dout_sync;
            pt = ifc.dout_trig;
            pl = ifc.dout_last;
            @(negedge clk);
        end
        ifc.arm       = 1'b0;
        ifc.din_valid = 1'b0;
        ifc.din_trig  = 1'b0;
        checks++;
        if (j != n) begin
            errors++;
            $display("FAIL %s count: got %0d samples want %0d", nm, j, n);
        end
        if (rdy_pct == 100) begin
            checks++;
            if (bub != 0) begin
                errors++;
                $display("FAIL %s throughput: got %0d bubbles want 0", nm, bub);
            end
        end
        check_idle(nm);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.dout_valid !== 1'b0 || ifc.dout_trig !== 1'b0 ||
            ifc.dout_last !== 1'b0 || ifc.armed !== 1'b0 ||
            ifc.triggered !== 1'b0) begin
            errors++;
            $display("FAIL reset: v/t/l/a/tr=%b%b%b%b%b want 00000",
                     ifc.dout_valid, ifc.dout_trig, ifc.dout_last,
                     ifc.armed, ifc.triggered);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_basic();
        run_capture("basic", 3, 4, 64'd1 << 10, 0, 100, 1'b1);
    endtask

    task automatic test_early_trig();
        run_capture("early_trig", 3, 2,
                    (64'd1 << 1) | (64'd1 << 2) | (64'd1 << 6), 0, 100, 1'b1);
    endtask

    task automatic test_wrap();
        logic [63:0] m;
        m = {32'($urandom), 32'($urandom)} | (64'd1 << 20);
        run_capture("wrap_clamp", 10, 10, m, 20, 100, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [63:0] m;
        for (int r = 0; r < 3; r++) begin
            m = {32'($urandom), 32'($urandom)} | (64'd1 << 30);
            run_capture("backpressure", 5, 6, m, 25, 30, 1'b0);
        end
    endtask

    task automatic test_single();
        run_capture("single", 0, 0, 64'd1, 0, 60, 1'b0);
    endtask

    task automatic test_abort();
        bit got;
        pulse_arm(2, 8);
        feed(5, 2);
        checks++;
        if (ifc.triggered !== 1'b1) begin
            errors++;
            $display("FAIL abort_post_setup: trig'd=%b want 1", ifc.triggered);
        end
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        check_idle("abort_post");

        ifc.dout_ready = 1'b0;
        pulse_arm(1, 1);
        feed(3, 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (ifc.dout_valid === 1'b1) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL abort_read_setup: dout_valid=0 want 1");
        end
        ifc.abort = 1'b1;
        ifc.arm   = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        ifc.arm   = 1'b0;
        check_idle("abort_readout");
        @(negedge clk);
        check_idle("abort_arm_ignored");

        pulse_arm(8, 2);
        feed(3, -1);
        checks++;
        if (ifc.armed !== 1'b1) begin
            errors++;
            $display("FAIL reset_fill_setup: armed=%b want 1", ifc.armed);
        end
        rst_n = 1'b0;
        #1;
        check_idle("reset_fill");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_capture("after_abort", 4, 3, 64'd1 << 6, 10, 50, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_trig();
        test_wrap();
        test_backpressure();
        test_single();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
